// File: rtl/lifo_test_seq.sv
// lifo_test_seq: self-checking push/replace/drain sequencer for a LIFO under test
module lifo_test_seq #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int SEED = 'h0D
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_run,
  output logic                           o_running,
  output logic                           o_passed,
  output logic                           o_failed,
  output logic [2:0]                     o_fail_state,
  output logic [$clog2(DEPTH+1)-1:0]     o_fail_k,
  output logic [WIDTH-1:0]               o_data,
  output logic                           o_push,
  output logic                           o_pop,
  input  logic [WIDTH-1:0]               i_s0,
  input  logic [WIDTH-1:0]               i_s1,
  input  logic                           i_empty,
  input  logic                           i_full
);
  localparam int KW = $clog2(DEPTH + 1);
  localparam logic [2:0] S_IDLE = 3'd0, S_PUSH = 3'd1, S_PCHK = 3'd2, S_RPL = 3'd3,
                         S_RCHK = 3'd4, S_POP = 3'd5, S_QCHK = 3'd6, S_END = 3'd7;
  localparam logic [KW-1:0] ONE = KW'(1), DK = KW'(DEPTH);
  logic [2:0] state, nxt;
  logic [KW-1:0] k, k_nxt;
  logic bad;
  function automatic logic [WIDTH-1:0] v(input logic [KW-1:0] n);
    return WIDTH'(SEED + 3 * int'(n));
  endfunction
  assign o_running = i_run && state != S_IDLE && state != S_END;
  assign o_push = i_run && (state == S_PUSH || state == S_RPL);
  assign o_pop = i_run && (state == S_RPL || state == S_POP);
  assign o_data = state == S_PUSH ? v(k) : state == S_RPL ? ~v(DK) : '0;
  // flag a UUT mismatch in the current check state
  always_comb begin
    bad = 1'b0;
    case (state)
      S_PCHK: bad = i_s0 != v(k) || (k > ONE && i_s1 != v(k - ONE)) || i_empty || i_full != (k == DK);
      S_RCHK: bad = i_s0 != ~v(DK) || i_s1 != v(DK - ONE) || !i_full || i_empty;
      S_QCHK: bad = i_empty != (k == '0) || i_full || (k != '0 && i_s0 != v(k)) || (k > ONE && i_s1 != v(k - ONE));
      default: bad = 1'b0;
    endcase
  end
  // sequence order: fill to full, replace top, drain to empty
  always_comb begin
    nxt = state;
    k_nxt = k;
    case (state)
      S_IDLE: begin nxt = S_PUSH; k_nxt = ONE; end
      S_PUSH: nxt = S_PCHK;
      S_PCHK: begin nxt = k == DK ? S_RPL : S_PUSH; k_nxt = k == DK ? k : k + ONE; end
      S_RPL: nxt = S_RCHK;
      S_RCHK: nxt = S_POP;
      S_POP: begin nxt = S_QCHK; k_nxt = k - ONE; end
      S_QCHK: nxt = k == '0 ? S_END : S_POP;
      default: nxt = S_END;
    endcase
  end
  // advance only while running; a mismatch wins over the normal transition
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      k <= '0;
      o_passed <= 1'b0;
      o_failed <= 1'b0;
      o_fail_state <= '0;
      o_fail_k <= '0;
    end else if (i_run && state != S_END) begin
      if (bad) begin
        state <= S_END;
        o_failed <= 1'b1;
        o_fail_state <= state;
        o_fail_k <= k;
      end else begin
        state <= nxt;
        k <= k_nxt;
        if (state == S_QCHK && k == '0) o_passed <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_lifo_test_seq.sv
// tb_lifo_test_seq: behavioural LIFO with fault modes plus a step-script model of the sequencer
module tb_lifo_test_seq;
  localparam int W = 8, D = 8, NS = 4 * D + 2;
  typedef struct {
    bit push, pop, chk, c0, c1, emp, ful;
    logic [W-1:0] data, s0, s1;
    logic [2:0] st;
    int k;
  } step_t;
  step_t sc[NS];
  logic clk = 0, rst = 1, run = 0;
  logic o_running, o_passed, o_failed, o_push, o_pop, empty, full;
  logic [2:0] o_fail_state;
  logic [3:0] o_fail_k;
  logic [W-1:0] o_data, s0, s1;
  int fault = 0, vectors = 0, miss = 0;
  always #5 clk = ~clk;
  lifo_test_seq #(.WIDTH(W), .DEPTH(D), .SEED('h0D)) dut (
    .i_clk(clk), .i_rst(rst), .i_run(run), .o_running(o_running), .o_passed(o_passed),
    .o_failed(o_failed), .o_fail_state(o_fail_state), .o_fail_k(o_fail_k), .o_data(o_data),
    .o_push(o_push), .o_pop(o_pop), .i_s0(s0), .i_s1(s1), .i_empty(empty), .i_full(full)
  );
  // stack under test: 0 good, 1 s0 stuck at 0, 2 full at D-1, 3 ignores replace
  logic [W-1:0] mem [D];
  int cnt = 0;
  always @(posedge clk)
    if (rst) cnt <= 0;
    else if (o_push && o_pop) begin if (fault != 3 && cnt > 0) mem[cnt-1] <= o_data; end
    else if (o_push && cnt < D) begin mem[cnt] <= o_data; cnt <= cnt + 1; end
    else if (o_pop && cnt > 0) cnt <= cnt - 1;
  assign s0 = (fault == 1 || cnt == 0) ? '0 : mem[cnt-1];
  assign s1 = cnt < 2 ? '0 : mem[cnt-2];
  assign empty = cnt == 0;
  assign full = fault == 2 ? cnt >= D - 1 : cnt == D;
  function automatic logic [W-1:0] v(int n);
    return W'(8'h0D + 3 * n);
  endfunction
  function automatic step_t act_step(bit pu, bit po, logic [W-1:0] d);
    step_t s = '{default: '0};
    s.push = pu; s.pop = po; s.data = d;
    return s;
  endfunction
  function automatic step_t chk_step(logic [W-1:0] q[$], logic [2:0] st, int k);
    step_t s = '{default: '0};
    s.chk = 1; s.st = st; s.k = k;
    s.emp = q.size() == 0; s.ful = q.size() == D;
    s.c0 = q.size() >= 1; s.c1 = q.size() >= 2;
    if (s.c0) s.s0 = q[$];
    if (s.c1) s.s1 = q[$-1];
    return s;
  endfunction
  task automatic chk(input string nm, input int a, input int e);
    vectors++;
    if (a != e) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
    end
  endtask
  // reference: position in the step script, advanced by run, stopped by first stack mismatch
  int p = -1, m_fk = 0;
  bit m_pass = 0, m_fail = 0, en = 0;
  logic [2:0] m_fs = 0;
  function automatic bit mism(step_t s);
    return (s.c0 && s0 != s.s0) || (s.c1 && s1 != s.s1) || empty != s.emp || full != s.ful;
  endfunction
  always @(posedge clk) begin
    if (rst) begin p = -1; m_pass = 0; m_fail = 0; m_fs = 0; m_fk = 0; en = 1; end
    else if (run && !m_pass && !m_fail) begin
      if (p < 0) p = 0;
      else if (sc[p].chk && mism(sc[p])) begin m_fail = 1; m_fs = sc[p].st; m_fk = sc[p].k; end
      else begin p++; m_pass = p == NS; end
    end
  end
  always @(negedge clk) begin : cmp
    step_t c;
    bit a;
    if (en) begin
      a = p >= 0 && !m_pass && !m_fail;
      c = sc[a ? p : 0];
      chk("running", o_running, run && a);
      chk("push", o_push, run && a && c.push);
      chk("pop", o_pop, run && a && c.pop);
      if (run && a && c.push) chk("data", o_data, c.data);
      chk("passed", o_passed, m_pass);
      chk("failed", o_failed, m_fail);
      chk("fail_state", o_fail_state, m_fs);
      chk("fail_k", o_fail_k, m_fk);
    end
  end
  task automatic do_run(input int f, input int pct, input int hold_at, input int hold_len,
                        input int rst_at, output int act, output int tot);
    int hold = hold_len;
    bit did = 0;
    fault = f; run = 0; rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_running", o_running, 0);
    chk("rst_passed", o_passed, 0);
    chk("rst_failed", o_failed, 0);
    chk("rst_fail_state", o_fail_state, 0);
    chk("rst_fail_k", o_fail_k, 0);
    chk("rst_push", o_push, 0);
    chk("rst_pop", o_pop, 0);
    chk("rst_data", o_data, 0);
    act = 0; tot = 0; run = 1;
    while (!(o_passed || o_failed) && tot < 400) begin
      @(negedge clk);
      tot++;
      if (o_running) act++;
      if (!did && act == rst_at) begin
        did = 1; rst = 1;
        @(negedge clk);
        rst = 0;
        chk("midrst_running", o_running, 0);
        chk("midrst_passed", o_passed, 0);
        chk("midrst_failed", o_failed, 0);
        chk("midrst_push", o_push, 0);
        act = 0; tot = 0; run = 1;
      end else if (hold > 0 && act == hold_at) begin
        run = 0; hold--;
      end else run = $urandom_range(99) >= pct;
    end
    chk("finished", o_passed || o_failed, 1);
  endtask
  initial begin
    logic [W-1:0] q[$];
    int n = 0, a, t, f;
    for (int k = 1; k <= D; k++) begin
      sc[n] = act_step(1, 0, v(k)); n++;
      q.push_back(v(k));
      sc[n] = chk_step(q, 3'd2, k); n++;
    end
    sc[n] = act_step(1, 1, ~v(D)); n++;
    q.pop_back(); q.push_back(~v(D));
    sc[n] = chk_step(q, 3'd4, D); n++;
    for (int k = D - 1; k >= 0; k--) begin
      sc[n] = act_step(0, 1, '0); n++;
      q.pop_back();
      sc[n] = chk_step(q, 3'd6, k); n++;
    end
    chk("script_len", n, NS);
    chk("script_v1", sc[0].data, 8'h10);
    chk("script_rpl", sc[16].data, 8'hDA);
    chk("script_last_empty", sc[NS-1].emp, 1);
    do_run(0, 0, -1, 0, -1, a, t);
    chk("t1_passed", o_passed, 1); chk("t1_failed", o_failed, 0);
    chk("t1_active", a, 34); chk("t1_len", t - 1, 34);
    do_run(1, 0, -1, 0, -1, a, t);
    chk("t2_failed", o_failed, 1); chk("t2_passed", o_passed, 0);
    chk("t2_state", o_fail_state, 2); chk("t2_k", o_fail_k, 1);
    do_run(2, 0, -1, 0, -1, a, t);
    chk("t3_failed", o_failed, 1); chk("t3_state", o_fail_state, 2); chk("t3_k", o_fail_k, 7);
    do_run(3, 0, -1, 0, -1, a, t);
    chk("t4_failed", o_failed, 1); chk("t4_state", o_fail_state, 4); chk("t4_k", o_fail_k, 8);
    do_run(0, 0, 25, 5, -1, a, t);
    chk("t5_passed", o_passed, 1); chk("t5_active", a, 34); chk("t5_len", t - 1, 39);
    do_run(0, 0, -1, 0, 10, a, t);
    chk("t6_passed", o_passed, 1); chk("t6_active", a, 34);
    for (int i = 0; i < 8; i++) begin
      f = $urandom_range(3);
      do_run(f, 30, -1, 0, -1, a, t);
      chk("rand_outcome", o_passed, f == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
